pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the model computer. Each cycle it takes one decoded control-flow operation and computes the next program counter. It drives the call stack directly: on CALL it pushes the return address, and on RET it pops the return address from the stack's data output. It sits between the instruction decoder (upstream) and the stack (downstream). It keeps its own shadow depth count so it can detect overflow and underflow before issuing an illegal stack operation.

## Interface
- WIDTH, 8, program-counter and stack-data width in bits
- DEPTH, 256, stack capacity in entries; the shadow depth counter is clog2(DEPTH)+1 bits wide

- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-low: state clears on the rising edge of clk while rst=0
- instr_valid  input  1  decoder presents a valid op this cycle
- op  input  3  operation: 000 NEXT, 001 JUMP, 010 JUMP_IF, 011 CALL, 100 RET, 101 HALT; 110/111 are treated as NEXT
- cond  input  1  branch condition, used only by JUMP_IF
- target  input  WIDTH  jump or call destination
- stk_data  input  WIDTH  stack read data; valid combinationally in any cycle where stk_pop=1 and the stack is non-empty
- pc  output  WIDTH  current program counter (registered)
- stk_push  output  1  push strobe to the stack (combinational)
- stk_pop  output  1  pop strobe to the stack (combinational)
- stk_value  output  WIDTH  data to push: (pc+1) mod 2^WIDTH
- depth  output  clog2(DEPTH)+1  shadow stack depth (registered)
- halted  output  1  sequencer is in HALT state
- fault  output  2  sticky error flags: bit0 overflow, bit1 underflow

## Operation
- Two-state FSM: RUN and HALT. Reset enters RUN. RUN→HALT on a HALT op, or on any fault. HALT→RUN only via reset.
- An op is accepted when state=RUN and instr_valid=1. In HALT, or when instr_valid=0, pc, depth and fault hold, and stk_push=stk_pop=0.
- NEXT: pc ← pc+1, wrapping from 2^WIDTH−1 to 0.
- JUMP: pc ← target.
- JUMP_IF: pc ← target if cond=1, else pc+1.
- CALL with depth<DEPTH:
  - stk_push=1 for the accepting cycle, with stk_value=pc+1 (wraps).
  - pc ← target; depth ← depth+1.
- CALL with depth=DEPTH:
  - stk_push=0; pc holds.
  - fault[0] ← 1; state ← HALT.
- RET with depth>0:
  - stk_pop=1 for the accepting cycle.
  - pc ← stk_data, sampled at the closing edge; depth ← depth−1.
- RET with depth=0:
  - stk_pop=0; pc holds.
  - fault[1] ← 1; state ← HALT.
- HALT op: pc holds; state ← HALT.
- stk_push and stk_pop are never both 1. Both are forced to 0 while rst=0.
- Fault bits clear only on reset. Once halted, no further bit can be set.

## Timing
- Reset values (applied at the first rising edge with rst=0):
  - pc=0, depth=0, fault=00, halted=0.
  - stk_push=stk_pop=0 combinationally during reset.
- Latency: one cycle. An op accepted in cycle N produces new pc/depth/halted/fault values visible in cycle N+1.
- stk_push, stk_pop and stk_value are combinational functions of op, instr_valid, state, depth and pc within cycle N. The stack updates its pointer at the same edge that updates pc.
- Back-to-back CALL/RET on consecutive cycles is legal. A RET immediately after a CALL returns to the caller's pc+1.
- Reset overrides everything, including an op presented in the same cycle. A CALL in flight during reset produces no push.
- The stack shares rst; the top level adapts polarity if the stack's reset differs.

## Test plan
- Reset, then hold op=NEXT, instr_valid=1 for 257 cycles → pc counts 0…255, then 0, 1; stk_push/stk_pop stay 0; depth stays 0.
- At pc=0x10: CALL target=0x40, then NEXT×2, then RET (stk_data=0x11) → stk_push=1 with stk_value=0x11 in the CALL cycle; pc sequence 0x40, 0x41, 0x42, 0x11; depth goes 1 then 0.
- RET with depth=0 → stk_pop stays 0, pc unchanged, fault=10, halted=1; subsequent ops are ignored until rst=0.
- DEPTH=4: CALL×5 → the first four push with depth 1…4; the fifth has no push, fault=01, halted=1, pc=target of the fourth CALL.
- Coverage checks:
  - JUMP_IF target=0x80 with cond=0 at pc=5 → pc=6; with cond=1 → pc=0x80.
  - instr_valid=0 → pc holds.
- rst=0 asserted in the same cycle as a CALL → no push; next cycle pc=0, depth=0, fault=00.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the model computer. Each cycle it accepts one
// decoded control-flow op from the instruction decoder and computes the next
// program counter. It drives the call stack directly (push on CALL, pop on
// RET). It keeps a shadow depth count so it can refuse an overflowing CALL or
// an underflowing RET before the stack ever sees it. When that happens, it
// raises a sticky fault bit and halts.
//
// Parameters
//   WIDTH        program-counter and stack-data width
//   DEPTH        stack capacity in entries
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-low reset
//   instr_valid  decoder presents a valid op this cycle
//   op           000 NEXT, 001 JUMP, 010 JUMP_IF, 011 CALL, 100 RET,
//                101 HALT, 110/111 behave as NEXT
//   cond         branch condition for JUMP_IF
//   target       jump / call destination
//   stk_data     stack read data, valid while stk_pop=1 on a non-empty stack
//   pc           current program counter (registered)
//   stk_push     push strobe to the stack (combinational)
//   stk_pop      pop strobe to the stack (combinational)
//   stk_value    return address to push, pc+1 with wrap
//   depth        shadow stack depth (registered)
//   halted       sequencer is in the HALT state
//   fault        sticky errors, bit0 overflow, bit1 underflow
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  input  logic [2:0]               op,
  input  logic                     cond,
  input  logic [WIDTH-1:0]         target,
  input  logic [WIDTH-1:0]         stk_data,
  output logic [WIDTH-1:0]         pc,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [WIDTH-1:0]         stk_value,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     halted,
  output logic [1:0]               fault
);

  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [2:0] OP_NEXT    = 3'b000;
  localparam logic [2:0] OP_JUMP    = 3'b001;
  localparam logic [2:0] OP_JUMP_IF = 3'b010;
  localparam logic [2:0] OP_CALL    = 3'b011;
  localparam logic [2:0] OP_RET     = 3'b100;
  localparam logic [2:0] OP_HALT    = 3'b101;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_pc;
  logic [DW-1:0]    r_depth;
  logic [1:0]       r_fault;

  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_isCall;
  logic             w_isRet;
  logic             w_isHalt;
  logic             w_overflow;
  logic             w_underflow;
  logic [WIDTH-1:0] w_pcInc;
  logic [WIDTH-1:0] w_pcNext;
  logic [DW-1:0]    w_depthNext;
  logic [1:0]       w_faultNext;

  // Op decode and stack bounds. An op only counts when running with a valid
  // instruction, so halted or idle cycles leave every piece of state alone.
  always_comb begin
    w_accept    = (r_state == ST_RUN) && instr_valid;
    w_full      = (r_depth == DW'(DEPTH));
    w_empty     = (r_depth == '0);
    w_isCall    = w_accept && (op == OP_CALL);
    w_isRet     = w_accept && (op == OP_RET);
    w_isHalt    = w_accept && (op == OP_HALT);
    w_overflow  = w_isCall && w_full;
    w_underflow = w_isRet && w_empty;
    w_pcInc     = r_pc + WIDTH'(1);
  end

  // State register for the RUN/HALT machine. Only reset leaves HALT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: a HALT op or either stack fault stops the sequencer.
  always_comb begin
    w_stateNext = r_state;
    if (r_state == ST_RUN) begin
      if (w_isHalt || w_overflow || w_underflow) begin
        w_stateNext = ST_HALT;
      end
    end
  end

  // Output logic. The stack strobes are gated by rst, so a CALL or RET
  // arriving in the same cycle as reset never reaches the stack.
  always_comb begin
    stk_push  = rst && w_isCall && !w_full;
    stk_pop   = rst && w_isRet && !w_empty;
    stk_value = w_pcInc;
    halted    = (r_state == ST_HALT);
    pc        = r_pc;
    depth     = r_depth;
    fault     = r_fault;
  end

  // Datapath next values. Faulting CALL/RET and the HALT op hold pc. The
  // fault bits are OR-ed in, so they stay sticky until reset.
  always_comb begin
    w_pcNext    = r_pc;
    w_depthNext = r_depth;
    w_faultNext = r_fault;
    if (w_accept) begin
      case (op)
        OP_JUMP:    w_pcNext = target;
        OP_JUMP_IF: w_pcNext = cond ? target : w_pcInc;
        OP_CALL: begin
          if (w_full) begin
            w_faultNext = r_fault | 2'b01;
          end else begin
            w_pcNext    = target;
            w_depthNext = r_depth + DW'(1);
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_faultNext = r_fault | 2'b10;
          end else begin
            w_pcNext    = stk_data;
            w_depthNext = r_depth - DW'(1);
          end
        end
        OP_HALT:    w_pcNext = r_pc;
        default:    w_pcNext = w_pcInc;
      endcase
    end
  end

  // Datapath registers: pc, shadow depth and sticky faults.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_fault <= 2'b00;
    end else begin
      r_pc    <= w_pcNext;
      r_depth <= w_depthNext;
      r_fault <= w_faultNext;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Two instances are used: dutA with the
// default DEPTH=256 and dutB with DEPTH=4, which makes overflow reachable.
// Each stimulus cycle pushes its hand-computed expectation into a queue. A
// monitor pops one entry per cycle on the falling edge and compares it with
// the selected instance.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [2:0] OP_NEXT    = 3'b000;
  localparam logic [2:0] OP_JUMP    = 3'b001;
  localparam logic [2:0] OP_JUMP_IF = 3'b010;
  localparam logic [2:0] OP_CALL    = 3'b011;
  localparam logic [2:0] OP_RET     = 3'b100;
  localparam logic [2:0] OP_HALT    = 3'b101;

  typedef struct {
    bit         sel;
    bit         chkState;
    logic [7:0] pc;
    logic [8:0] depth;
    logic       halted;
    logic [1:0] fault;
    logic       push;
    logic       pop;
    logic [7:0] value;
  } exp_t;

  logic clk;

  logic       rstA, validA, condA;
  logic [2:0] opA;
  logic [7:0] targetA, stkDataA;
  logic [7:0] pcA, stkValueA;
  logic       pushA, popA, haltedA;
  logic [8:0] depthA;
  logic [1:0] faultA;

  logic       rstB, validB, condB;
  logic [2:0] opB;
  logic [7:0] targetB, stkDataB;
  logic [7:0] pcB, stkValueB;
  logic       pushB, popB, haltedB;
  logic [2:0] depthB;
  logic [1:0] faultB;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   cycleNo = 0;

  pc_sequencer #(.WIDTH(8), .DEPTH(256)) dutA (
    .clk(clk), .rst(rstA), .instr_valid(validA), .op(opA), .cond(condA),
    .target(targetA), .stk_data(stkDataA), .pc(pcA), .stk_push(pushA),
    .stk_pop(popA), .stk_value(stkValueA), .depth(depthA),
    .halted(haltedA), .fault(faultA)
  );

  pc_sequencer #(.WIDTH(8), .DEPTH(4)) dutB (
    .clk(clk), .rst(rstB), .instr_valid(validB), .op(opB), .cond(condB),
    .target(targetB), .stk_data(stkDataB), .pc(pcB), .stk_push(pushB),
    .stk_pop(popB), .stk_value(stkValueB), .depth(depthB),
    .halted(haltedB), .fault(faultB)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end else begin
      nPass++;
    end
  endtask

  // Drive one cycle of stimulus into the selected instance and queue the
  // values that instance must show during that same cycle.
  task automatic applyStimulus(
    input bit sel, input logic rstv, input logic valid, input logic [2:0] op,
    input logic cond, input logic [7:0] target, input logic [7:0] stkData,
    input bit chkState, input logic [7:0] expPc, input logic [8:0] expDepth,
    input logic expHalted, input logic [1:0] expFault,
    input logic expPush, input logic expPop, input logic [7:0] expValue);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel == 1'b0) begin
      rstA = rstv; validA = valid; opA = op; condA = cond;
      targetA = target; stkDataA = stkData;
      rstB = 1'b1; validB = 1'b0; opB = OP_NEXT;
    end else begin
      rstB = rstv; validB = valid; opB = op; condB = cond;
      targetB = target; stkDataB = stkData;
      rstA = 1'b1; validA = 1'b0; opA = OP_NEXT;
    end
    e.sel = sel; e.chkState = chkState; e.pc = expPc; e.depth = expDepth;
    e.halted = expHalted; e.fault = expFault; e.push = expPush;
    e.pop = expPop; e.value = expValue;
    expQ.push_back(e);
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cycleNo++;
        if (e.sel == 1'b0) begin
          checkOutput("push", cycleNo, {31'b0, pushA}, {31'b0, e.push});
          checkOutput("pop",  cycleNo, {31'b0, popA},  {31'b0, e.pop});
          if (e.chkState) begin
            checkOutput("pc",     cycleNo, {24'b0, pcA},      {24'b0, e.pc});
            checkOutput("depth",  cycleNo, {23'b0, depthA},   {23'b0, e.depth});
            checkOutput("halted", cycleNo, {31'b0, haltedA},  {31'b0, e.halted});
            checkOutput("fault",  cycleNo, {30'b0, faultA},   {30'b0, e.fault});
            checkOutput("value",  cycleNo, {24'b0, stkValueA}, {24'b0, e.value});
          end
        end else begin
          checkOutput("B.push", cycleNo, {31'b0, pushB}, {31'b0, e.push});
          checkOutput("B.pop",  cycleNo, {31'b0, popB},  {31'b0, e.pop});
          if (e.chkState) begin
            checkOutput("B.pc",     cycleNo, {24'b0, pcB},      {24'b0, e.pc});
            checkOutput("B.depth",  cycleNo, {29'b0, depthB},   {23'b0, e.depth});
            checkOutput("B.halted", cycleNo, {31'b0, haltedB},  {31'b0, e.halted});
            checkOutput("B.fault",  cycleNo, {30'b0, faultB},   {30'b0, e.fault});
            checkOutput("B.value",  cycleNo, {24'b0, stkValueB}, {24'b0, e.value});
          end
        end
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstA = 1'b1; validA = 1'b0; opA = OP_NEXT; condA = 1'b0; targetA = '0; stkDataA = '0;
    rstB = 1'b1; validB = 1'b0; opB = OP_NEXT; condB = 1'b0; targetB = '0; stkDataB = '0;

    // Reset with a CALL presented: no push while rst=0.
    applyStimulus(0, 0, 1, OP_CALL, 0, 8'h40, 8'h00, 0, 8'h00, 9'd0, 0, 2'b00, 0, 0, 8'h00);

    // 257 NEXT ops: pc counts 0..255 then wraps to 0, no stack traffic.
    for (int i = 0; i < 257; i++) begin
      applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'(i), 9'd0, 0, 2'b00, 0, 0, 8'(i + 1));
    end

    // pc is now 1. Jump to 0x10, then CALL / NEXT / NEXT / RET.
    applyStimulus(0, 1, 1, OP_JUMP, 0, 8'h10, 8'h00, 1, 8'h01, 9'd0, 0, 2'b00, 0, 0, 8'h02);
    applyStimulus(0, 1, 1, OP_CALL, 0, 8'h40, 8'h00, 1, 8'h10, 9'd0, 0, 2'b00, 1, 0, 8'h11);
    applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h40, 9'd1, 0, 2'b00, 0, 0, 8'h41);
    applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h41, 9'd1, 0, 2'b00, 0, 0, 8'h42);
    applyStimulus(0, 1, 1, OP_RET,  0, 8'h00, 8'h11, 1, 8'h42, 9'd1, 0, 2'b00, 0, 1, 8'h43);
    applyStimulus(0, 1, 1, OP_JUMP, 0, 8'h05, 8'h00, 1, 8'h11, 9'd0, 0, 2'b00, 0, 0, 8'h12);

    // JUMP_IF not taken, then taken, then idle cycles hold pc.
    applyStimulus(0, 1, 1, OP_JUMP_IF, 0, 8'h80, 8'h00, 1, 8'h05, 9'd0, 0, 2'b00, 0, 0, 8'h06);
    applyStimulus(0, 1, 1, OP_JUMP_IF, 1, 8'h80, 8'h00, 1, 8'h06, 9'd0, 0, 2'b00, 0, 0, 8'h07);
    applyStimulus(0, 1, 0, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h80, 9'd0, 0, 2'b00, 0, 0, 8'h81);
    applyStimulus(0, 1, 0, OP_CALL, 0, 8'h33, 8'h00, 1, 8'h80, 9'd0, 0, 2'b00, 0, 0, 8'h81);

    // Back-to-back CALL then RET returns to caller pc+1.
    applyStimulus(0, 1, 1, OP_CALL, 0, 8'h20, 8'h00, 1, 8'h80, 9'd0, 0, 2'b00, 1, 0, 8'h81);
    applyStimulus(0, 1, 1, OP_RET,  0, 8'h00, 8'h81, 1, 8'h20, 9'd1, 0, 2'b00, 0, 1, 8'h21);
    applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h81, 9'd0, 0, 2'b00, 0, 0, 8'h82);

    // CALL, then a CALL in the same cycle as reset: no push, state cleared.
    applyStimulus(0, 1, 1, OP_CALL, 0, 8'h30, 8'h00, 1, 8'h82, 9'd0, 0, 2'b00, 1, 0, 8'h83);
    applyStimulus(0, 0, 1, OP_CALL, 0, 8'h50, 8'h00, 1, 8'h30, 9'd1, 0, 2'b00, 0, 0, 8'h31);

    // RET on an empty stack: underflow fault, then everything is ignored.
    applyStimulus(0, 1, 1, OP_RET,  0, 8'h00, 8'h77, 1, 8'h00, 9'd0, 0, 2'b00, 0, 0, 8'h01);
    applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h00, 9'd0, 1, 2'b10, 0, 0, 8'h01);
    applyStimulus(0, 1, 1, OP_CALL, 0, 8'h44, 8'h00, 1, 8'h00, 9'd0, 1, 2'b10, 0, 0, 8'h01);
    applyStimulus(0, 1, 1, OP_RET,  0, 8'h00, 8'h55, 1, 8'h00, 9'd0, 1, 2'b10, 0, 0, 8'h01);
    applyStimulus(0, 0, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h00, 9'd0, 1, 2'b10, 0, 0, 8'h01);

    // After reset: running again; a HALT op stops it without faults.
    applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h00, 9'd0, 0, 2'b00, 0, 0, 8'h01);
    applyStimulus(0, 1, 1, OP_HALT, 0, 8'h00, 8'h00, 1, 8'h01, 9'd0, 0, 2'b00, 0, 0, 8'h02);
    applyStimulus(0, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h01, 9'd0, 1, 2'b00, 0, 0, 8'h02);

    // DEPTH=4 instance: four CALLs push, the fifth overflows and halts.
    applyStimulus(1, 0, 0, OP_NEXT, 0, 8'h00, 8'h00, 0, 8'h00, 9'd0, 0, 2'b00, 0, 0, 8'h00);
    applyStimulus(1, 1, 1, OP_CALL, 0, 8'h10, 8'h00, 1, 8'h00, 9'd0, 0, 2'b00, 1, 0, 8'h01);
    applyStimulus(1, 1, 1, OP_CALL, 0, 8'h20, 8'h00, 1, 8'h10, 9'd1, 0, 2'b00, 1, 0, 8'h11);
    applyStimulus(1, 1, 1, OP_CALL, 0, 8'h30, 8'h00, 1, 8'h20, 9'd2, 0, 2'b00, 1, 0, 8'h21);
    applyStimulus(1, 1, 1, OP_CALL, 0, 8'h40, 8'h00, 1, 8'h30, 9'd3, 0, 2'b00, 1, 0, 8'h31);
    applyStimulus(1, 1, 1, OP_CALL, 0, 8'h50, 8'h00, 1, 8'h40, 9'd4, 0, 2'b00, 0, 0, 8'h41);
    applyStimulus(1, 1, 1, OP_RET,  0, 8'h00, 8'h99, 1, 8'h40, 9'd4, 1, 2'b01, 0, 0, 8'h41);
    applyStimulus(1, 1, 1, OP_NEXT, 0, 8'h00, 8'h00, 1, 8'h40, 9'd4, 1, 2'b01, 0, 0, 8'h41);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    nChecks++;
    if (expQ.size() != 0) begin
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end else begin
      nPass++;
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
